// File: rtl/fc_mac_if.sv
// Handshake bundle for fc_mac_unit: neuron start, beat stream and result channel.
// The unit side uses the slave modport; the driver of beats and consumer of results uses master.
interface fc_mac_if #(
  parameter int SIZE     = 16,
  parameter int INPUT_SZ = 4,
  parameter int BEAT_W   = 8
);
  logic                     start;
  logic [SIZE-1:0]          bias;
  logic [BEAT_W-1:0]        beats;
  logic                     in_valid;
  logic                     in_ready;
  logic [INPUT_SZ*SIZE-1:0] weights;
  logic [INPUT_SZ*SIZE-1:0] inputs;
  logic                     out_valid;
  logic                     out_ready;
  logic [SIZE-1:0]          value;
  logic                     overflow;
  logic                     busy;

  modport master (
    output start, bias, beats, in_valid, weights, inputs, out_ready,
    input  in_ready, out_valid, value, overflow, busy
  );

  modport slave (
    input  start, bias, beats, in_valid, weights, inputs, out_ready,
    output in_ready, out_valid, value, overflow, busy
  );
endinterface

// File: rtl/fc_mac_unit.sv
// Two-stage multiply-accumulate for one fully-connected neuron, saturating Q(SIZE-PRECISION).PRECISION result.
// Optional ReLU on the result when FC_RELU_EN is defined.
module fc_mac_unit #(
  parameter int SIZE      = 16,
  parameter int PRECISION = 11,
  parameter int INPUT_SZ  = 4,
  parameter int GUARD     = 8,
  parameter int BEAT_W    = 8
) (
  input  logic     clk,
  input  logic     rst,
  fc_mac_if.slave  bus
);
  localparam int ACC_W = 2*SIZE + GUARD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]          psum_q, psum_d;
  logic                      psum_vld_q, psum_vld_d;
  logic [BEAT_W-1:0]         remaining_q, remaining_d;
  logic [SIZE-1:0]           value_q, value_d;
  logic                      overflow_q, overflow_d;
  logic [ACC_W-1:0]          dot_s;
  logic [ACC_W-1:0]          bias_ext_s;

  // Returns {clipped, value}; the shift floors toward -inf, then the upper bits decide clipping.
  function automatic logic [SIZE:0] sat_fn(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    logic [ACC_W-SIZE:0]     hi;
    logic                    neg;
    logic                    clip;
    logic [SIZE-1:0]         v;
    sh   = a >>> PRECISION;
    hi   = sh[ACC_W-1:SIZE-1];
    neg  = sh[ACC_W-1];
    clip = !((&hi) || !(|hi));
    if (clip) begin
      v = neg ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
    end else begin
      v = sh[SIZE-1:0];
    end
`ifdef FC_RELU_EN
    if (neg) begin
      v    = '0;
      clip = 1'b0;
    end else begin
      v    = v;
    end
`endif
    return {clip, v};
  endfunction

  // Lane-wise signed products summed at accumulator width.
  always_comb begin
    dot_s = '0;
    for (int i = 0; i < INPUT_SZ; i++) begin
      logic signed [SIZE-1:0]   w_s;
      logic signed [SIZE-1:0]   x_s;
      logic signed [2*SIZE-1:0] prod_s;
      w_s    = bus.weights[i*SIZE +: SIZE];
      x_s    = bus.inputs[i*SIZE +: SIZE];
      prod_s = (2*SIZE)'(w_s) * (2*SIZE)'(x_s);
      dot_s  = dot_s + {{GUARD{prod_s[2*SIZE-1]}}, prod_s};
    end
  end

  assign bias_ext_s = {{(ACC_W-SIZE){bus.bias[SIZE-1]}}, bus.bias} << PRECISION;

  // Next-state and datapath control; stage 2 absorbs any pending psum every cycle.
  always_comb begin
    state_d     = state_q;
    psum_d      = psum_q;
    psum_vld_d  = 1'b0;
    remaining_d = remaining_q;
    value_d     = value_q;
    overflow_d  = overflow_q;
    if (psum_vld_q) begin
      acc_d = acc_q + psum_q;
    end else begin
      acc_d = acc_q;
    end
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d       = bias_ext_s;
          remaining_d = bus.beats;
          state_d     = (bus.beats != '0) ? ACCUM : FLUSH;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          psum_d      = dot_s;
          psum_vld_d  = 1'b1;
          remaining_d = remaining_q - BEAT_W'(1);
          state_d     = (remaining_q == BEAT_W'(1)) ? FLUSH : ACCUM;
        end else begin
          state_d = ACCUM;
        end
      end
      FLUSH: begin
        {overflow_d, value_d} = sat_fn(acc_d);
        state_d               = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      psum_q      <= '0;
      psum_vld_q  <= 1'b0;
      remaining_q <= '0;
      value_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      psum_q      <= psum_d;
      psum_vld_q  <= psum_vld_d;
      remaining_q <= remaining_d;
      value_q     <= value_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.value     = value_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fc_mac_unit.sv
// Randomized bench for fc_mac_unit against an integer-arithmetic neuron model, plus directed cases.
module tb_fc_mac_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        exp_active = 1'b0;
  logic [15:0] exp_value  = 16'h0;
  logic        exp_ovf    = 1'b0;
  logic [63:0] wv [8];
  logic [63:0] xv [8];

  fc_mac_if #(.SIZE(16), .INPUT_SZ(4), .BEAT_W(8)) bus ();

  fc_mac_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Neuron result straight from the arithmetic: bias*2^11 + sum of products, floor-shift, clip.
  function automatic logic [16:0] model(input logic [15:0] b, input longint total);
    longint acc;
    longint sh;
    logic [15:0] v;
    logic ov;
    acc = (longint'($signed(b)) * 2048) + total;
    sh  = acc >>> 11;
    if (sh > 32767) begin
      v = 16'h7FFF; ov = 1'b1;
    end else if (sh < -32768) begin
      v = 16'h8000; ov = 1'b1;
    end else begin
      v = sh[15:0]; ov = 1'b0;
    end
`ifdef FC_RELU_EN
    if (sh < 0) begin
      v = 16'h0000; ov = 1'b0;
    end
`endif
    return {ov, v};
  endfunction

  function automatic logic [15:0] rnd16();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    else return 16'($urandom_range(0, 2047)) - 16'd1024;
  endfunction

  task automatic fill(input logic [15:0] w, input logic [15:0] x);
    for (int k = 0; k < 8; k++) begin
      wv[k] = {4{w}};
      xv[k] = {4{x}};
    end
  endtask

  // Result checker: whenever a result is presented, it must match the model.
  always @(negedge clk) begin
    if (!rst && exp_active && bus.out_valid) begin
      check("cmp_value", {48'h0, bus.value}, {48'h0, exp_value});
      check("cmp_ovf", {63'h0, bus.overflow}, {63'h0, exp_ovf});
      check("cmp_rdy_in_done", {63'h0, bus.in_ready}, 64'h0);
    end
  end

  task automatic run_neuron(input logic [15:0] b, input int nb, input int maxgap, input int hold,
                            input bit pulse, output logic [15:0] got_v, output logic got_o);
    longint total;
    logic [16:0] e;
    total = 0;
    for (int k = 0; k < nb; k++)
      for (int i = 0; i < 4; i++)
        total += longint'($signed(wv[k][i*16 +: 16])) * longint'($signed(xv[k][i*16 +: 16]));
    e = model(b, total);
    exp_value  = e[15:0];
    exp_ovf    = e[16];
    exp_active = 1'b1;
    check("idle_busy", {63'h0, bus.busy}, 64'h0);
    bus.start = 1'b1; bus.bias = b; bus.beats = nb[7:0];
    @(negedge clk);
    bus.start = 1'b0; bus.bias = 16'($urandom); bus.beats = 8'($urandom);
    check("t1_busy", {63'h0, bus.busy}, 64'h1);
    check("t1_rdy", {63'h0, bus.in_ready}, {63'h0, (nb != 0)});
    for (int k = 0; k < nb; k++) begin
      int g;
      g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      for (int j = 0; j < g; j++) begin
        bus.in_valid = 1'b0; bus.weights = {2{$urandom}}; bus.inputs = {2{$urandom}};
        @(negedge clk);
      end
      check("beat_rdy", {63'h0, bus.in_ready}, 64'h1);
      bus.in_valid = 1'b1; bus.weights = wv[k]; bus.inputs = xv[k];
      bus.out_ready = 1'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1; bus.weights = {2{$urandom}}; bus.inputs = {2{$urandom}};
    check("flush_rdy", {63'h0, bus.in_ready}, 64'h0);
    check("flush_ov", {63'h0, bus.out_valid}, 64'h0);
    check("flush_busy", {63'h0, bus.busy}, 64'h1);
    bus.out_ready = (hold == 0);
    @(negedge clk);
    check("done_ov", {63'h0, bus.out_valid}, 64'h1);
    check("done_rdy", {63'h0, bus.in_ready}, 64'h0);
    got_v = bus.value;
    got_o = bus.overflow;
    for (int h = 0; h < hold; h++) begin
      bus.start = pulse; bus.bias = 16'($urandom); bus.beats = 8'h00;
      @(negedge clk);
      check("hold_ov", {63'h0, bus.out_valid}, 64'h1);
      check("hold_val", {48'h0, bus.value}, {48'h0, got_v});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_ov", {63'h0, bus.out_valid}, 64'h0);
    check("post_busy", {63'h0, bus.busy}, 64'h0);
    bus.start = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    exp_active = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_rdy"}, {63'h0, bus.in_ready}, 64'h0);
    check({nm, "_ov"}, {63'h0, bus.out_valid}, 64'h0);
    check({nm, "_val"}, {48'h0, bus.value}, 64'h0);
    check({nm, "_ovf"}, {63'h0, bus.overflow}, 64'h0);
    check({nm, "_busy"}, {63'h0, bus.busy}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic        o;
    rst = 1'b1;
    bus.start = 1'b0; bus.bias = 16'h0; bus.beats = 8'h0; bus.in_valid = 1'b0;
    bus.weights = 64'h0; bus.inputs = 64'h0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Pin the model to hand-computed values.
    check("pin_basic", {47'h0, model(16'h0800, 4 * 64'd4194304)}, {47'h0, 17'h02800});
    check("pin_sat", {47'h0, model(16'h7FFF, 8 * (64'd32767 * 64'd32767))}, {47'h0, 17'h17FFF});

    fill(16'h0800, 16'h0800);
    run_neuron(16'h0800, 1, 0, 0, 1'b0, v, o);
    check("basic_val", {48'h0, v}, 64'h2800);
    check("basic_ovf", {63'h0, o}, 64'h0);

    fill(16'hF800, 16'h1000);
    run_neuron(16'h0000, 1, 0, 0, 1'b0, v, o);
`ifdef FC_RELU_EN
    check("neg_val", {48'h0, v}, 64'h0000);
`else
    check("neg_val", {48'h0, v}, 64'hC000);
`endif

    fill(16'h7FFF, 16'h7FFF);
    run_neuron(16'h7FFF, 2, 0, 0, 1'b0, v, o);
    check("sat_val", {48'h0, v}, 64'h7FFF);
    check("sat_ovf", {63'h0, o}, 64'h1);

    fill(16'h0800, 16'h0800);
    run_neuron(16'h0000, 3, 2, 0, 1'b0, v, o);
    check("gaps_val", {48'h0, v}, 64'h6000);

    run_neuron(16'h1234, 0, 0, 5, 1'b1, v, o);
    check("zero_beats_val", {48'h0, v}, 64'h1234);

    // Abort a three-beat neuron after its first beat.
    fill(16'h0800, 16'h0800);
    bus.start = 1'b1; bus.bias = 16'h0800; bus.beats = 8'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.weights = wv[0]; bus.inputs = xv[0];
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_neuron(16'h0800, 1, 0, 0, 1'b0, v, o);
    check("after_abort_val", {48'h0, v}, 64'h2800);

    for (int n = 0; n < 40; n++) begin
      int nb;
      nb = $urandom_range(0, 6);
      for (int k = 0; k < 8; k++)
        for (int i = 0; i < 4; i++) begin
          wv[k][i*16 +: 16] = rnd16();
          xv[k][i*16 +: 16] = rnd16();
        end
      run_neuron(rnd16(), nb, 2, $urandom_range(0, 3), 1'($urandom), v, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
